// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared encodings and defaults for the convolution scratch memory.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2
  } state_t;

  typedef enum logic [2:0] {
    MS_IDLE       = 3'd0,
    MS_DATA_VALID = 3'd1,
    MS_WRITE_DONE = 3'd2,
    MS_ALL_DONE   = 3'd3
  } ms_t;

  localparam logic [2:0] C_CS_ACK = 3'd1;
  localparam int         C_PIX_W  = 8;
  localparam int         C_RES_W  = 32;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/mem_result_bank.sv
`default_nettype none
// ============================================================================
// Module      : mem_result_bank
// Description : TILES-deep pair of result memories with a write port and a
//               registered read-back of the most recently written slot.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_result_bank
  import mem_pkg::*;
#(
  parameter int TILES = 4,
  parameter int RES_W = C_RES_W,
  parameter int PTR_W = (TILES > 1) ? $clog2(TILES) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [RES_W-1:0] din22,
  input  logic [RES_W-1:0] din33,
  output logic [RES_W-1:0] ret22,
  output logic [RES_W-1:0] ret33
);

  logic [RES_W-1:0] r_mem22 [TILES];
  logic [RES_W-1:0] r_mem33 [TILES];
  logic [PTR_W-1:0] r_last;
  logic [RES_W-1:0] r_ret22;
  logic [RES_W-1:0] r_ret33;

  // The write cycle bypasses the array; afterwards the slot is read back, so
  // the outputs hold while the pointer in the top level moves on.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TILES; i++) begin
        r_mem22[i] <= '0;
        r_mem33[i] <= '0;
      end
      r_last  <= '0;
      r_ret22 <= '0;
      r_ret33 <= '0;
    end else if (we) begin
      r_mem22[waddr] <= din22;
      r_mem33[waddr] <= din33;
      r_last         <= waddr;
      r_ret22        <= din22;
      r_ret33        <= din33;
    end else begin
      r_ret22 <= r_mem22[r_last];
      r_ret33 <= r_mem33[r_last];
    end
  end

  assign ret22 = r_ret22;
  assign ret33 = r_ret33;

endmodule : mem_result_bank
`default_nettype wire

// File: rtl/memory_module.sv
`default_nettype none
// ============================================================================
// Module      : memory_module
// Description : Tile/filter scratch memory and status FSM for the convolution engine.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_module
  import mem_pkg::*;
#(
  parameter int TILES = 4,
  parameter int PIX_W = C_PIX_W,
  parameter int RES_W = C_RES_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          state,
  input  logic [2:0]          CS,
  input  logic [RES_W-1:0]    inret22,
  input  logic [RES_W-1:0]    inret33,
  output logic [2:0]          MS,
  output logic [16*PIX_W-1:0] DATA,
  output logic [9*PIX_W-1:0]  FILTER,
  output logic [RES_W-1:0]    ret22,
  output logic [RES_W-1:0]    ret33
);

  localparam int               PTR_W  = (TILES > 1) ? $clog2(TILES) : 1;
  localparam logic [PTR_W-1:0] C_LAST = PTR_W'(TILES - 1);

  logic [16*PIX_W-1:0] r_img [TILES];
  logic [9*PIX_W-1:0]  r_filt;
  logic [PTR_W-1:0]    r_ptr;
  ms_t                 r_ms;
  logic [16*PIX_W-1:0] r_data;
  logic [9*PIX_W-1:0]  r_filter;

  logic w_read;
  logic w_write;
  logic w_ack;

  // Codes 3-7 decode to neither command and so behave as IDLE.
  assign w_read  = (state == ST_READ);
  assign w_write = (state == ST_WRITE);
  assign w_ack   = (CS == C_CS_ACK) && (r_ms == MS_WRITE_DONE) && !w_write;

  // Tile and filter contents are fixed patterns loaded by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TILES; i++) begin
        for (int k = 0; k < 16; k++) begin
          r_img[i][k*PIX_W +: PIX_W] <= PIX_W'(16 * i + k);
        end
      end
      for (int k = 0; k < 9; k++) begin
        r_filt[k*PIX_W +: PIX_W] <= PIX_W'(k + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr    <= '0;
      r_ms     <= MS_IDLE;
      r_data   <= '0;
      r_filter <= '0;
    end else if (w_read) begin
      r_data   <= r_img[r_ptr];
      r_filter <= r_filt;
      r_ms     <= MS_DATA_VALID;
    end else if (w_write) begin
      r_ms <= MS_WRITE_DONE;
    end else if (w_ack) begin
      if (r_ptr == C_LAST) begin
        r_ptr <= '0;
        r_ms  <= MS_ALL_DONE;
      end else begin
        r_ptr <= r_ptr + PTR_W'(1);
        r_ms  <= MS_IDLE;
      end
    end
  end

  mem_result_bank #(
    .TILES (TILES),
    .RES_W (RES_W),
    .PTR_W (PTR_W)
  ) u_result_bank (
    .clk   (clk),
    .rst   (rst),
    .we    (w_write),
    .waddr (r_ptr),
    .din22 (inret22),
    .din33 (inret33),
    .ret22 (ret22),
    .ret33 (ret33)
  );

  assign MS     = r_ms;
  assign DATA   = r_data;
  assign FILTER = r_filter;

endmodule : memory_module
`default_nettype wire

// File: tb/tb_memory_module.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_module
// Description : Directed, table-driven self-checking bench for memory_module.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_module;

  localparam logic [127:0] T0   = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] T1   = 128'h1F1E1D1C1B1A19181716151413121110;
  localparam logic [127:0] T2   = 128'h2F2E2D2C2B2A29282726252423222120;
  localparam logic [127:0] T3   = 128'h3F3E3D3C3B3A39383736353433323130;
  localparam logic [71:0]  FILT = 72'h090807060504030201;

  localparam logic [31:0] R0 = 32'd124812789;
  localparam logic [31:0] Q0 = 32'd12828;
  localparam logic [31:0] RA = 32'hDEADBEEF;
  localparam logic [31:0] QA = 32'h12345678;
  localparam logic [31:0] RC = 32'h000000FF;
  localparam logic [31:0] QC = 32'hFFFFFFFF;
  localparam logic [31:0] RE = 32'h80000001;
  localparam logic [31:0] QE = 32'h7FFFFFFE;
  localparam logic [31:0] RG = 32'hA5A55A5A;
  localparam logic [31:0] QG = 32'h0F0FF0F0;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [2:0]   state = 3'd0;
  logic [2:0]   CS = 3'd0;
  logic [31:0]  inret22 = '0;
  logic [31:0]  inret33 = '0;
  logic [2:0]   MS;
  logic [127:0] DATA;
  logic [71:0]  FILTER;
  logic [31:0]  ret22;
  logic [31:0]  ret33;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [2:0]   st;
    logic [2:0]   cs;
    logic [31:0]  i22;
    logic [31:0]  i33;
    logic [2:0]   ms;
    logic [127:0] data;
    logic [71:0]  filt;
    logic [31:0]  r22;
    logic [31:0]  r33;
  } vec_t;

  vec_t vecs [20];

  memory_module #(
    .TILES (4),
    .PIX_W (8),
    .RES_W (32)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .state   (state),
    .CS      (CS),
    .inret22 (inret22),
    .inret33 (inret33),
    .MS      (MS),
    .DATA    (DATA),
    .FILTER  (FILTER),
    .ret22   (ret22),
    .ret33   (ret33)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] ms, input logic [127:0] data,
                         input logic [71:0] filt, input logic [31:0] r22, input logic [31:0] r33);
    chk({tag, ".MS"},     128'(MS),     128'(ms));
    chk({tag, ".DATA"},   DATA,         data);
    chk({tag, ".FILTER"}, 128'(FILTER), 128'(filt));
    chk({tag, ".ret22"},  128'(ret22),  128'(r22));
    chk({tag, ".ret33"},  128'(ret33),  128'(r33));
  endtask

  function automatic vec_t mk(input logic [2:0] st, input logic [2:0] cs, input logic [31:0] i22,
                              input logic [31:0] i33, input logic [2:0] ms, input logic [127:0] data,
                              input logic [31:0] r22, input logic [31:0] r33);
    vec_t v;
    v.st = st; v.cs = cs; v.i22 = i22; v.i33 = i33;
    v.ms = ms; v.data = data; v.filt = FILT; v.r22 = r22; v.r33 = r33;
    return v;
  endfunction

  initial begin
    //            st    cs    in22 in33  MS    DATA ret22 ret33
    vecs[0]  = mk(3'd1, 3'd0, '0, '0,   3'd1, T0, '0, '0);
    vecs[1]  = mk(3'd1, 3'd0, '0, '0,   3'd1, T0, '0, '0);
    vecs[2]  = mk(3'd2, 3'd0, R0, Q0,   3'd2, T0, R0, Q0);
    vecs[3]  = mk(3'd2, 3'd0, R0, Q0,   3'd2, T0, R0, Q0);
    vecs[4]  = mk(3'd0, 3'd0, '0, '0,   3'd2, T0, R0, Q0);
    vecs[5]  = mk(3'd0, 3'd1, '0, '0,   3'd0, T0, R0, Q0);  // ACK -> ptr 1
    vecs[6]  = mk(3'd1, 3'd0, '0, '0,   3'd1, T1, R0, Q0);
    vecs[7]  = mk(3'd2, 3'd1, RA, QA,   3'd2, T1, RA, QA);  // WRITE beats ACK
    vecs[8]  = mk(3'd0, 3'd0, '0, '0,   3'd2, T1, RA, QA);
    vecs[9]  = mk(3'd0, 3'd1, '0, '0,   3'd0, T1, RA, QA);  // ptr 2
    vecs[10] = mk(3'd2, 3'd0, RC, QC,   3'd2, T1, RC, QC);
    vecs[11] = mk(3'd1, 3'd1, '0, '0,   3'd1, T2, RC, QC);  // READ beats ACK
    vecs[12] = mk(3'd2, 3'd0, RE, QE,   3'd2, T2, RE, QE);
    vecs[13] = mk(3'd0, 3'd1, '0, '0,   3'd0, T2, RE, QE);  // ptr 3
    vecs[14] = mk(3'd1, 3'd0, '0, '0,   3'd1, T3, RE, QE);
    vecs[15] = mk(3'd0, 3'd1, '0, '0,   3'd1, T3, RE, QE);  // ACK in DATA_VALID ignored
    vecs[16] = mk(3'd2, 3'd0, RG, QG,   3'd2, T3, RG, QG);
    vecs[17] = mk(3'd5, 3'd1, '0, '0,   3'd3, T3, RG, QG);  // code 5 is IDLE; wrap
    vecs[18] = mk(3'd0, 3'd1, '0, '0,   3'd3, T3, RG, QG);
    vecs[19] = mk(3'd1, 3'd0, '0, '0,   3'd1, T0, RG, QG);

    #1 rst = 1'b0;
    #2;
    chk_all("in_reset", 3'd0, '0, '0, '0, '0);
    #18 rst = 1'b1;
    @(negedge clk);
    chk_all("after_reset", 3'd0, '0, '0, '0, '0);

    for (int i = 0; i < 20; i++) begin
      state   = vecs[i].st;
      CS      = vecs[i].cs;
      inret22 = vecs[i].i22;
      inret33 = vecs[i].i33;
      @(negedge clk);
      chk_all($sformatf("vec%0d", i), vecs[i].ms, vecs[i].data, vecs[i].filt,
              vecs[i].r22, vecs[i].r33);
    end

    // Advance ptr to 1, then abort a WRITE with an asynchronous reset.
    state = 3'd2; CS = 3'd0; inret22 = 32'h11111111; inret33 = 32'h22222222;
    @(negedge clk);
    state = 3'd0; CS = 3'd1;
    @(negedge clk);
    chk("seq.ack.MS", 128'(MS), 128'(3'd0));
    state = 3'd1; CS = 3'd0;
    @(negedge clk);
    chk("seq.read1.DATA", DATA, T1);
    state = 3'd2; inret22 = 32'h33333333; inret33 = 32'h44444444;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk_all("async_reset", 3'd0, '0, '0, '0, '0);
    @(negedge clk);
    rst = 1'b1; state = 3'd0;
    @(negedge clk);
    chk_all("post_reset_idle", 3'd0, '0, '0, '0, '0);
    state = 3'd1;
    @(negedge clk);
    chk_all("post_reset_read", 3'd1, T0, FILT, '0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_memory_module
`default_nettype wire

// File: doc/memory_module.md
Name: memory_module

Overview:
- Local scratch memory for a small convolution engine.
- Holds TILES packed 4x4 8-bit image tiles and one packed 3x3 8-bit filter.
- On controller request, presents the current tile and the filter to the compute unit, then stores the 2x2 and 3x3 results (ret22, ret33) the compute unit returns.
- Sits between the top-level controller (`state`, `CS`) and the convolution datapath; reports its own progress on `MS`.

Parameters:
- TILES, 4, number of image tiles stored; power of two, at least 2.
- PIX_W, 8, bits per pixel and filter tap.
- RES_W, 32, width of each result word.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- state  in  3  controller command: 0 IDLE, 1 READ, 2 WRITE; values 3-7 are treated as IDLE.
- CS  in  3  compute status: 1 = ACK (compute unit has consumed the write-back); any other value = no action.
- inret22  in  RES_W  2x2 convolution result to store.
- inret33  in  RES_W  3x3 convolution result to store.
- MS  out  3  memory status: 0 IDLE, 1 DATA_VALID, 2 WRITE_DONE, 3 ALL_DONE.
- DATA  out  16*PIX_W  current image tile; pixel k at bits [8k+7:8k], k = row*4 + col.
- FILTER  out  9*PIX_W  filter; tap k at bits [8k+7:8k].
- ret22  out  RES_W  last stored 2x2 result.
- ret33  out  RES_W  last stored 3x3 result.

Behaviour:
- All outputs are registered. Inputs are sampled on the rising edge of `clk`; responses appear one cycle later.
- Reset (rst low, asynchronous):
  - DATA, FILTER, ret22, ret33 = 0; MS = IDLE; tile pointer ptr = 0.
  - img_mem[i] byte k = (16*i + k) mod 256.
  - Filter byte k = k+1.
  - Result memories res22_mem and res33_mem cleared to 0.
- Reset asserted mid-operation aborts everything and restores the reset values above.
- state READ, every edge:
  - DATA <= img_mem[ptr]; FILTER <= filter; MS <= DATA_VALID.
  - A READ clears a sticky ALL_DONE.
- state WRITE, every edge:
  - res22_mem[ptr] <= inret22; res33_mem[ptr] <= inret33.
  - ret22 <= inret22; ret33 <= inret33; MS <= WRITE_DONE.
  - Repeated WRITE cycles overwrite the same slot; ptr does not move.
- state IDLE: DATA, FILTER, ret22 and ret33 hold their values.
- ACK (CS == 1), honoured only when MS == WRITE_DONE and state != WRITE:
  - If ptr < TILES-1: ptr <= ptr+1 and MS <= IDLE.
  - If ptr == TILES-1: ptr wraps to 0 and MS <= ALL_DONE.
- ACK in any other MS value is ignored.
- Simultaneous events:
  - WRITE together with ACK: the WRITE wins and the ACK is ignored.
  - READ together with ACK: the READ wins and ptr is unchanged.
- ALL_DONE holds until reset or a READ. WRITE in ALL_DONE is allowed and targets tile 0.
- No arithmetic on data; widths are fixed by the parameters.

Decomposition:
- Shared package `mem_pkg` holds:
  - state_t command encoding (IDLE, READ, WRITE);
  - ms_t status encoding (IDLE, DATA_VALID, WRITE_DONE, ALL_DONE);
  - the CS_ACK constant;
  - PIX_W and RES_W defaults.
- One natural sub-module: `mem_result_bank`, the TILES-deep pair of RES_W result memories with its write port and ptr-indexed read.
- Tile storage and the status FSM stay in the top level.

Test Plan:
- Hold rst low 20 ns, then release -> DATA=0, FILTER=0, ret22=0, ret33=0, MS=0.
- state=1 for 2 cycles -> DATA=128'h0F0E0D0C0B0A09080706050403020100, FILTER=72'h090807060504030201, MS=1.
- inret22=124812789, inret33=12828, state=2 for 2 cycles -> ret22=124812789, ret33=12828, MS=2; after state=0 the values hold.
- Then CS=1 with state=0 for 1 cycle -> MS=0, ptr=1; next READ gives DATA=128'h1F1E1D1C1B1A19181716151413121110.
- Run 4 full READ/WRITE/ACK rounds -> after the 4th ACK MS=3; next READ gives the tile-0 pattern again and MS=1.
- CS=1 in the same cycle as state=2 -> MS=2 and ptr unchanged. Pulse rst low during WRITE -> all outputs 0 and MS=0 immediately, without waiting for a clock edge.
